// File: rtl/ahb2apb_bridge_if.sv
// AHB-Lite and APB bus bundles used by ahb2apb_bridge.
// The bridge takes ahbif.slave and apbif.master.
interface ahb2apb_ahb_if #(parameter int AW = 32, parameter int DW = 32);
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [3:0]    hmaster;
  logic [DW-1:0] hwdata;
  logic          hmasterlock;
  logic          hreadym;
  logic [3:0]    hauser;
  logic [3:0]    hwuser;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;
  logic [3:0]    hruser;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmaster, hwdata,
           hmasterlock, hreadym, hauser, hwuser,
    output hrdata, hready, hresp, hruser
  );
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmaster, hwdata,
           hmasterlock, hreadym, hauser, hwuser,
    input  hrdata, hready, hresp, hruser
  );
endinterface

interface ahb2apb_apb_if #(parameter int PAW = 16, parameter int DW = 32);
  logic           psel;
  logic [PAW-1:0] paddr;
  logic           penable;
  logic           pwrite;
  logic [3:0]     pstrb;
  logic [2:0]     pprot;
  logic [31:0]    pwdata;
  logic           apbactive;
  logic [DW-1:0]  prdata;
  logic           pready;
  logic           pslverr;

  modport master (
    output psel, paddr, penable, pwrite, pstrb, pprot, pwdata, apbactive,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, paddr, penable, pwrite, pstrb, pprot, pwdata, apbactive,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// Unbuffered AHB-Lite to APB3/APB4 bridge, one transfer outstanding at a time.
// Optional APB access timeout under macro APB_TIMEOUT_EN.
module ahb2apb_bridge #(
  parameter int AW  = 32,
  parameter int PAW = 16,
  parameter int DW  = 32,
  parameter int TOW = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  ahb2apb_ahb_if.slave         ahbif,
  ahb2apb_apb_if.master        apbif
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;
  state_t state, state_nx;

  logic accept;
  logic timeout;

  assign accept = ahbif.hsel & ahbif.hreadym & ahbif.htrans[1] & ahbif.hready;

  function automatic logic [3:0] strb_dec(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'd0:    strb_dec = 4'b0001 << a;
      3'd1:    strb_dec = a[1] ? 4'b1100 : 4'b0011;
      default: strb_dec = 4'b1111;
    endcase
  endfunction

`ifdef APB_TIMEOUT_EN
  logic [TOW-1:0] to_cnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                               to_cnt <= '0;
    else if (state == SETUP)                   to_cnt <= '0;
    else if (state == ACCESS && !apbif.pready) to_cnt <= to_cnt + 1'b1;
  end
  assign timeout = &to_cnt;
`else
  logic [TOW-1:0] unused_to;
  assign unused_to = '0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    ahbif.hready    = 1'b1;
    ahbif.hresp     = 1'b0;
    apbif.psel      = 1'b0;
    apbif.penable   = 1'b0;
    apbif.apbactive = (state != IDLE);
    case (state)
      IDLE, DONE, ERR2: begin
        if (state == ERR2) ahbif.hresp = 1'b1;
        if (accept) state_nx = (ahbif.hsize > 3'd2) ? ERR1 : SETUP;
        else        state_nx = IDLE;
      end
      SETUP: begin
        ahbif.hready = 1'b0;
        apbif.psel   = 1'b1;
        state_nx     = ACCESS;
      end
      ACCESS: begin
        ahbif.hready  = 1'b0;
        apbif.psel    = 1'b1;
        apbif.penable = 1'b1;
        // pready in the same cycle as the final count takes precedence
        if (apbif.pready) state_nx = apbif.pslverr ? ERR1 : DONE;
        else if (timeout) state_nx = ERR1;
      end
      ERR1: begin
        ahbif.hready = 1'b0;
        ahbif.hresp  = 1'b1;
        state_nx     = ERR2;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      apbif.paddr  <= '0;
      apbif.pwrite <= 1'b0;
      apbif.pstrb  <= '0;
      apbif.pprot  <= '0;
      apbif.pwdata <= '0;
      ahbif.hrdata <= '0;
    end else begin
      if (accept) begin
        apbif.paddr  <= ahbif.haddr[PAW-1:0];
        apbif.pwrite <= ahbif.hwrite;
        apbif.pstrb  <= ahbif.hwrite ? strb_dec(ahbif.hsize, ahbif.haddr[1:0]) : 4'b0000;
        apbif.pprot  <= {~ahbif.hprot[0], 1'b0, ahbif.hprot[1]};
      end
      // SETUP coincides with the AHB data phase, so hwdata is valid here
      if (state == SETUP) apbif.pwdata <= ahbif.hwdata;
      if (state == ACCESS && apbif.pready && !apbif.pslverr && !apbif.pwrite)
        ahbif.hrdata <= apbif.prdata;
    end
  end

  assign ahbif.hruser = 4'b0000;

  logic unused_in;
  assign unused_in = ^{ahbif.haddr[AW-1:PAW], ahbif.htrans[0], ahbif.hburst,
                       ahbif.hprot[3:2], ahbif.hmaster, ahbif.hmasterlock,
                       ahbif.hauser, ahbif.hwuser};

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: APB accesses are scoreboarded
// against expectations queued when each AHB transfer is issued.
module tb_ahb2apb_bridge;

`ifdef APB_TIMEOUT_EN
  localparam int TB_TOW = 4;
`else
  localparam int TB_TOW = 8;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ahb2apb_ahb_if #(.AW(32), .DW(32)) ahbif();
  ahb2apb_apb_if #(.PAW(16), .DW(32)) apbif();

  ahb2apb_bridge #(.AW(32), .PAW(16), .DW(32), .TOW(TB_TOW)) dut (
    .clk(clk), .resetn(resetn), .ahbif(ahbif.slave), .apbif(apbif.master)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [2:0]  prot;
  } apb_t;

  apb_t exp_q[$];
  apb_t obs_q[$];
  int   obs_rd = 0;
  int   psel_cyc = 0;
  int   pen_cyc = 0;
  int   total = 0;
  int   bad = 0;

  // APB slave model: wait_n wait states per access
  int          wait_n = 0;
  int          acc_cnt;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) acc_cnt <= 0;
    else if (apbif.psel && apbif.penable && !apbif.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign apbif.pready  = apbif.psel & apbif.penable & (acc_cnt >= wait_n);
  assign apbif.pslverr = slv_err;
  assign apbif.prdata  = slv_rdata;
  assign ahbif.hreadym = ahbif.hready;

  always @(negedge clk) begin
    if (apbif.psel) psel_cyc++;
    if (apbif.psel && apbif.penable) pen_cyc++;
    if (apbif.psel && apbif.penable && apbif.pready)
      obs_q.push_back({apbif.paddr, apbif.pwrite, apbif.pstrb,
                       apbif.pwrite ? apbif.pwdata : 32'h0, apbif.pprot});
  end

  task automatic ahb_addr(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                          input logic [1:0] tr, input logic [3:0] prot, input logic [31:0] wd);
    ahbif.hsel = 1'b1; ahbif.haddr = a; ahbif.hwrite = wr; ahbif.hsize = sz;
    ahbif.htrans = tr; ahbif.hprot = prot;
    @(posedge clk); #1;
    ahbif.hsel = 1'b0; ahbif.htrans = 2'b00; ahbif.hwdata = wd;
  endtask

  task automatic ahb_wait(output int low, output logic lresp, output logic lpsel,
                          output logic fresp, output logic fpsel, output logic [31:0] rd,
                          output logic fps, output logic fpe, output logic act, output logic tmo);
    low = 0; lresp = 0; lpsel = 0; fresp = 0; fpsel = 0; rd = 0;
    fps = 0; fpe = 0; act = 1; tmo = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!apbif.apbactive) act = 0;
      if (i == 0) begin fps = apbif.psel; fpe = apbif.penable; end
      if (ahbif.hready) begin
        fresp = ahbif.hresp; fpsel = apbif.psel; rd = ahbif.hrdata; tmo = 0;
        break;
      end
      low++; lresp = ahbif.hresp; lpsel = apbif.psel;
    end
  endtask

  int          low;
  logic        lresp, lpsel, fresp, fpsel, fps, fpe, act, tmo;
  logic [31:0] rd;
  apb_t        e, got;

  task automatic test_reset;
    #12;
    total++;
    if ({ahbif.hready, ahbif.hresp, ahbif.hrdata, ahbif.hruser} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
      bad++; $display("FAIL reset_ahb got=%h want=%h", {ahbif.hready, ahbif.hresp, ahbif.hrdata, ahbif.hruser}, {1'b1, 1'b0, 32'h0, 4'h0});
    end
    total++;
    if ({apbif.psel, apbif.penable, apbif.pwrite, apbif.paddr, apbif.pstrb, apbif.pprot, apbif.pwdata, apbif.apbactive} !== 59'h0) begin
      bad++; $display("FAIL reset_apb got=%h want=0", {apbif.psel, apbif.penable, apbif.pwrite, apbif.paddr, apbif.pstrb, apbif.pprot, apbif.pwdata, apbif.apbactive});
    end
    #11 resetn = 1'b1;
  endtask

  task automatic test_word_write;
    wait_n = 0;
    exp_q.push_back({16'h1234, 1'b1, 4'b1111, 32'hDEADBEEF, 3'b001});
    @(posedge clk); #1;
    ahb_addr(32'h0000_1234, 1'b1, 3'd2, 2'b10, 4'b0011, 32'hDEADBEEF);
    ahb_wait(low, lresp, lpsel, fresp, fpsel, rd, fps, fpe, act, tmo);
    total++;
    if (tmo !== 1'b0 || low !== 2 || fresp !== 1'b0) begin
      bad++; $display("FAIL ww_timing tmo=%0b low=%0d resp=%0b want 0/2/0", tmo, low, fresp);
    end
    total++;
    if (fps !== 1'b1 || fpe !== 1'b0) begin
      bad++; $display("FAIL ww_setup psel=%0b penable=%0b want 1/0", fps, fpe);
    end
    total++;
    if (obs_q.size() <= obs_rd) begin bad++; $display("FAIL ww_apb no access seen"); end
    else begin
      got = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front();
      if (got !== e) begin bad++; $display("FAIL ww_apb got=%h want=%h", got, e); end
    end
  endtask

  task automatic test_read_wait;
    wait_n = 2; slv_rdata = 32'h5A5A5A5A;
    exp_q.push_back({16'h0042, 1'b0, 4'b0000, 32'h0, 3'b001});
    @(posedge clk); #1;
    ahb_addr(32'h0000_0042, 1'b0, 3'd0, 2'b10, 4'b0011, 32'h0);
    ahb_wait(low, lresp, lpsel, fresp, fpsel, rd, fps, fpe, act, tmo);
    total++;
    if (tmo !== 1'b0 || low !== 4 || fresp !== 1'b0) begin
      bad++; $display("FAIL rd_timing tmo=%0b low=%0d resp=%0b want 0/4/0", tmo, low, fresp);
    end
    total++;
    if (rd !== 32'h5A5A5A5A) begin bad++; $display("FAIL rd_data got=%h want=5a5a5a5a", rd); end
    total++;
    if (obs_q.size() <= obs_rd) begin bad++; $display("FAIL rd_apb no access seen"); end
    else begin
      got = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front();
      if (got !== e) begin bad++; $display("FAIL rd_apb got=%h want=%h", got, e); end
    end
    wait_n = 0;
  endtask

  task automatic test_strobe;
    logic [31:0] ta [4] = '{32'h0000_0043, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001};
    logic [2:0]  ts [4] = '{3'd0, 3'd1, 3'd1, 3'd0};
    logic [3:0]  tp [4] = '{4'b0000, 4'b0011, 4'b0001, 4'b0010};
    logic [3:0]  es [4] = '{4'b1000, 4'b1100, 4'b0011, 4'b0010};
    logic [2:0]  ep [4] = '{3'b100, 3'b001, 3'b000, 3'b101};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({ta[i][15:0], 1'b1, es[i], 32'h100 + i, ep[i]});
      @(posedge clk); #1;
      ahb_addr(ta[i], 1'b1, ts[i], 2'b10, tp[i], 32'h100 + i);
      ahb_wait(low, lresp, lpsel, fresp, fpsel, rd, fps, fpe, act, tmo);
      total++;
      if (obs_q.size() <= obs_rd) begin bad++; $display("FAIL strb_%0d no access seen", i); end
      else begin
        got = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front();
        if (got !== e) begin bad++; $display("FAIL strb_%0d got=%h want=%h", i, got, e); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic act1;
    wait_n = 0; slv_rdata = 32'hCAFEF00D;
    exp_q.push_back({16'h0100, 1'b1, 4'b1111, 32'h11111111, 3'b001});
    exp_q.push_back({16'h0104, 1'b0, 4'b0000, 32'h0, 3'b001});
    @(posedge clk); #1;
    ahb_addr(32'h0000_0100, 1'b1, 3'd2, 2'b10, 4'b0011, 32'h11111111);
    ahb_wait(low, lresp, lpsel, fresp, fpsel, rd, fps, fpe, act, tmo);
    act1 = act;
    ahb_addr(32'h0000_0104, 1'b0, 3'd2, 2'b10, 4'b0011, 32'h0);
    ahb_wait(low, lresp, lpsel, fresp, fpsel, rd, fps, fpe, act, tmo);
    total++;
    if (fps !== 1'b1 || fpe !== 1'b0 || low !== 2) begin
      bad++; $display("FAIL b2b_setup psel=%0b penable=%0b low=%0d want 1/0/2", fps, fpe, low);
    end
    total++;
    if (act1 !== 1'b1 || act !== 1'b1) begin
      bad++; $display("FAIL b2b_active got=%0b%0b want=11", act1, act);
    end
    total++;
    if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_rdata got=%h want=cafef00d", rd); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs_q.size() <= obs_rd) begin bad++; $display("FAIL b2b_apb%0d no access seen", i); end
      else begin
        got = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front();
        if (got !== e) begin bad++; $display("FAIL b2b_apb%0d got=%h want=%h", i, got, e); end
      end
    end
  endtask

  task automatic test_slverr;
    wait_n = 0; slv_err = 1'b1;
    exp_q.push_back({16'h0200, 1'b1, 4'b1111, 32'h0BADF00D, 3'b001});
    @(posedge clk); #1;
    ahb_addr(32'h0000_0200, 1'b1, 3'd2, 2'b10, 4'b0011, 32'h0BADF00D);
    ahb_wait(low, lresp, lpsel, fresp, fpsel, rd, fps, fpe, act, tmo);
    slv_err = 1'b0;
    total++;
    if (tmo !== 1'b0 || low !== 3 || lresp !== 1'b1 || lpsel !== 1'b0) begin
      bad++; $display("FAIL err1 tmo=%0b low=%0d hresp=%0b psel=%0b want 0/3/1/0", tmo, low, lresp, lpsel);
    end
    total++;
    if (fresp !== 1'b1 || fpsel !== 1'b0) begin
      bad++; $display("FAIL err2 hresp=%0b psel=%0b want 1/0", fresp, fpsel);
    end
    total++;
    if (obs_q.size() <= obs_rd) begin bad++; $display("FAIL err_apb no access seen"); end
    else begin
      got = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front();
      if (got !== e) begin bad++; $display("FAIL err_apb got=%h want=%h", got, e); end
    end
  endtask

  task automatic test_size_busy;
    int p0;
    p0 = psel_cyc;
    @(posedge clk); #1;
    ahb_addr(32'h0000_0300, 1'b1, 3'd3, 2'b10, 4'b0011, 32'h0);
    ahb_wait(low, lresp, lpsel, fresp, fpsel, rd, fps, fpe, act, tmo);
    total++;
    if (tmo !== 1'b0 || low !== 1 || lresp !== 1'b1 || fresp !== 1'b1) begin
      bad++; $display("FAIL size3_err tmo=%0b low=%0d r1=%0b r2=%0b want 0/1/1/1", tmo, low, lresp, fresp);
    end
    @(negedge clk);
    total++;
    if (ahbif.hresp !== 1'b0 || ahbif.hready !== 1'b1 || psel_cyc !== p0) begin
      bad++; $display("FAIL size3_after hresp=%0b hready=%0b pselcyc=%0d want 0/1/%0d", ahbif.hresp, ahbif.hready, psel_cyc, p0);
    end
    @(posedge clk); #1;
    ahb_addr(32'h0000_0400, 1'b1, 3'd2, 2'b01, 4'b0011, 32'h0);
    @(negedge clk);
    total++;
    if (ahbif.hready !== 1'b1 || apbif.apbactive !== 1'b0 || psel_cyc !== p0) begin
      bad++; $display("FAIL busy hready=%0b apbactive=%0b pselcyc=%0d want 1/0/%0d", ahbif.hready, apbif.apbactive, psel_cyc, p0);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    n0 = obs_q.size();
    wait_n = 1000;
    @(posedge clk); #1;
    ahb_addr(32'h0000_0500, 1'b0, 3'd2, 2'b10, 4'b0011, 32'h0);
    @(negedge clk); @(negedge clk);
    total++;
    if (apbif.psel !== 1'b1 || apbif.penable !== 1'b1) begin
      bad++; $display("FAIL rstmid_access psel=%0b penable=%0b want 1/1", apbif.psel, apbif.penable);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({apbif.psel, apbif.penable, apbif.apbactive, ahbif.hready, ahbif.hresp} !== 5'b00010) begin
      bad++; $display("FAIL rstmid_async got=%b want=00010", {apbif.psel, apbif.penable, apbif.apbactive, ahbif.hready, ahbif.hresp});
    end
    total++;
    if (ahbif.hrdata !== 32'h0 || obs_q.size() !== n0) begin
      bad++; $display("FAIL rstmid_clear hrdata=%h acc=%0d want 0/%0d", ahbif.hrdata, obs_q.size(), n0);
    end
    @(posedge clk); #2 resetn = 1'b1;
    wait_n = 0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    int n0, e0;
    n0 = obs_q.size(); e0 = pen_cyc;
    wait_n = 100000;
    @(posedge clk); #1;
    ahb_addr(32'h0000_0600, 1'b0, 3'd2, 2'b10, 4'b0011, 32'h0);
    ahb_wait(low, lresp, lpsel, fresp, fpsel, rd, fps, fpe, act, tmo);
    total++;
    if (tmo !== 1'b0 || low !== 18 || lresp !== 1'b1 || fresp !== 1'b1) begin
      bad++; $display("FAIL timeout_resp tmo=%0b low=%0d r1=%0b r2=%0b want 0/18/1/1", tmo, low, lresp, fresp);
    end
    total++;
    if (pen_cyc - e0 !== 16 || obs_q.size() !== n0) begin
      bad++; $display("FAIL timeout_access cycles=%0d acc=%0d want 16/%0d", pen_cyc - e0, obs_q.size(), n0);
    end
    wait_n = 0;
  endtask
`endif

  initial begin
    resetn = 1'b0;
    ahbif.hsel = 1'b0; ahbif.haddr = '0; ahbif.htrans = 2'b00; ahbif.hwrite = 1'b0;
    ahbif.hsize = 3'd2; ahbif.hburst = 3'd0; ahbif.hprot = 4'b0011; ahbif.hmaster = 4'h0;
    ahbif.hwdata = '0; ahbif.hmasterlock = 1'b0; ahbif.hauser = 4'h0; ahbif.hwuser = 4'h0;
    test_reset;
    test_word_write;
    test_read_wait;
    test_strobe;
    test_back_to_back;
    test_slverr;
    test_size_busy;
    test_reset_mid;
`ifdef APB_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
